mole_round_ctrl: RTL
====================

# mole_round_ctrl

Round controller for the whack-a-mole game: sequences one timed round from start to finish and owns the game state. It generates mole patterns, detects hits from the one-hot keypad, and keeps score, combo and fever-mode scheduling. It also drives the end-of-round light sequence. It sits between the tick divider and keypad inputs and the score/combo display, LCD and melody blocks, which consume its outputs.

## Interface
- ROUND_TICKS, 45, round length in ticks; timer reload value (1..255)
- COMBO_TH, 10, consecutive hits that arm fever (1..15)
- FEVER_TICKS, 5, tick windows spent in fever (1..15)
- LFSR_SEED, 8'hA5, non-zero mole LFSR reset value

- clk  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- tick  in  1  one-clk strobe marking a mole-window boundary
- start  in  1  level; sampled only in IDLE and DONE
- keypad  in  8  raw key levels, bit n = hole n
- mole  out  8  lit holes
- score  out  8  saturating score
- combo  out  4  consecutive-hit count, saturates at 15
- timer  out  8  remaining ticks
- fever  out  1  high in FEVER state
- finish  out  1  high in DONE state

## Operation
- States: IDLE, RUN, FEVER, END_OFF, DONE.
- IDLE: mole=0, timer=ROUND_TICKS. When start=1, on the next clk:
  - score=0, combo=0
  - mole=current LFSR value, LFSR advances
  - go to RUN.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances only when a new RUN mole is loaded. Never zero.
- Key press: press = keypad & ~keypad_q, where keypad_q is keypad registered one clk. A press is valid only if exactly one bit rises. Multi-bit rises are ignored.
- Hit: valid press with (press & mole)!=0 in RUN/FEVER, while hit_done=0. Effects:
  - score += 1 (RUN) or 3 (FEVER), saturating at 255
  - combo += 1 in RUN only, saturating at 15; unchanged in FEVER
  - the pressed mole bit clears
  - hit_done=1
- Wrong key: valid press with no mole match in RUN sets combo=0. Ignored in FEVER.
- Tick in RUN/FEVER:
  - timer -= 1
  - in RUN, if hit_done=0, combo=0
  - hit_done=0
  - new mole loaded.
- RUN → FEVER at a tick when combo≥COMBO_TH. fever_cnt=0; mole=8'hF0.
- FEVER: mole alternates 8'hF0 / 8'h0F on each tick; fever_cnt+1 per tick. At the tick where fever_cnt reaches FEVER_TICKS: go to RUN, combo=0, mole from LFSR.
- End of round: a tick with timer==1 in RUN or FEVER gives timer=0, mole=8'h00, → END_OFF. This takes priority over fever entry and exit.
- END_OFF: key presses ignored. Next tick gives mole=8'hFF, → DONE.
- DONE: finish=1, mole=8'hFF; outputs hold. When start=1: restart as from IDLE, with timer=ROUND_TICKS, finish=0.

## Timing
- Reset values: state IDLE, mole 0, score 0, combo 0, timer ROUND_TICKS, fever 0, finish 0, LFSR LFSR_SEED, keypad_q 0, hit_done 0.
- Press-to-score latency: 2 clk after the keypad edge (one clk for the edge register, one clk for the update).
- Hit and tick in the same clk: the hit is credited to the ending window.
  - Score and combo update with the hit, and combo is not cleared.
  - The new mole is loaded and hit_done=0 after that clk.
  - A hit that reaches COMBO_TH in that clk enters FEVER at that same tick.
- A tick in IDLE or DONE is ignored. start held high in RUN is ignored.
- RESET_N low mid-round: immediate return to reset values, regardless of tick or keypad.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MOLE_FEVER_EN defined: fever behaviour as described.
- MOLE_FEVER_EN undefined:
  - FEVER is never entered and fever is tied to 0.
  - combo still counts and saturates at 15.
  - all hits score +1.

## Test plan
- Reset, then start pulse, tick never asserted → state RUN, timer=45, mole=8'hA5's LFSR successor load (mole=8'hA5), score=0.
- With mole=8'hA5, press key bit0 (rise 0→1), no tick → score=1 and combo=1 after 2 clk, mole=8'hA4. A second press of bit2 in the same window → no change.
- 10 consecutive windows, each with a hit, then tick → fever=1, mole=8'hF0. Hit bit7 → score +3. After 5 ticks → fever=0, combo=0, RUN.
- A window with no press, then tick → combo=0. A wrong-key press in RUN → combo=0 immediately; score unchanged.
- Score at 254, hit in FEVER → score=255 (saturated).
- 45 ticks from start → mole=8'h00, timer=0. Next tick → mole=8'hFF, finish=1. start → finish=0, score=0, timer=45. RESET_N low mid-round → all reset values asynchronously.

Source files
------------

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round sequencer: moles, hits, score, combo, fever, end lights
// Build option MOLE_FEVER_EN enables the fever bonus mode; without it FEVER is never entered.
`timescale 1ns/1ps
module mole_round_ctrl #(
  parameter int unsigned ROUND_TICKS = 45,
  parameter int unsigned COMBO_TH    = 10,
  parameter int unsigned FEVER_TICKS = 5,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic [7:0] keypad_i,
  output logic [7:0] mole_o,
  output logic [7:0] score_o,
  output logic [3:0] combo_o,
  output logic [7:0] timer_o,
  output logic       fever_o,
  output logic       finish_o
);

`ifdef MOLE_FEVER_EN
  localparam bit FEVER_EN = 1'b1;
`else
  localparam bit FEVER_EN = 1'b0;
`endif

  localparam logic [7:0] ROUND_TICKS_L = 8'(ROUND_TICKS);
  localparam logic [3:0] COMBO_TH_L    = 4'(COMBO_TH);
  localparam logic [3:0] FEVER_TICKS_L = 4'(FEVER_TICKS);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FEVER, S_END_OFF, S_DONE} state_e;

  state_e     state_q;
  logic [7:0] lfsr_q, key_s_q, keypad_q, mole_q, score_q, timer_q;
  logic [3:0] combo_q, fever_cnt_q;
  logic       hit_done_q, fever_q, finish_q;

  logic [7:0] press, lfsr_d, score_hit_d;
  logic [8:0] score_sum;
  logic [3:0] combo_hit_d, combo_tick_d, fever_cnt_d;
  logic       press_valid, in_play, hit, wrong, fever_go;

  // key_s_q is the edge register; press is formed one clk later so scoring lands 2 clk after the key edge
  always_comb begin
    press       = key_s_q & ~keypad_q;
    press_valid = $onehot(press);
    in_play     = (state_q == S_RUN) || (state_q == S_FEVER);
    hit         = in_play && press_valid && (|(press & mole_q)) && !hit_done_q;
    wrong       = (state_q == S_RUN) && press_valid && !(|(press & mole_q));
    lfsr_d      = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    score_sum   = {1'b0, score_q} + ((FEVER_EN && state_q == S_FEVER) ? 9'd3 : 9'd1);
    score_hit_d = score_sum[8] ? 8'hFF : score_sum[7:0];
    combo_hit_d = combo_q;
    if (state_q == S_RUN) begin
      if (hit)        combo_hit_d = (combo_q == 4'hF) ? 4'hF : combo_q + 4'd1;
      else if (wrong) combo_hit_d = 4'd0;
    end
    // a window that ends without any hit (including one landing on the tick) breaks the combo
    combo_tick_d = (state_q == S_RUN && !hit_done_q && !hit) ? 4'd0 : combo_hit_d;
    fever_go     = FEVER_EN && (combo_tick_d >= COMBO_TH_L);
    fever_cnt_d  = fever_cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      key_s_q     <= 8'h00;
      keypad_q    <= 8'h00;
      mole_q      <= 8'h00;
      score_q     <= 8'h00;
      combo_q     <= 4'd0;
      timer_q     <= ROUND_TICKS_L;
      fever_cnt_q <= 4'd0;
      hit_done_q  <= 1'b0;
      fever_q     <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      key_s_q  <= keypad_i;
      keypad_q <= key_s_q;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_RUN;
            mole_q     <= lfsr_q;
            lfsr_q     <= lfsr_d;
            score_q    <= 8'h00;
            combo_q    <= 4'd0;
            timer_q    <= ROUND_TICKS_L;
            hit_done_q <= 1'b0;
            finish_q   <= 1'b0;
            fever_q    <= 1'b0;
          end
        end
        S_RUN, S_FEVER: begin
          combo_q <= combo_hit_d;
          if (hit) begin
            score_q    <= score_hit_d;
            mole_q     <= mole_q & ~press;
            hit_done_q <= 1'b1;
          end
          if (tick_i) begin
            hit_done_q <= 1'b0;
            combo_q    <= combo_tick_d;
            if (timer_q == 8'd1) begin
              timer_q <= 8'd0;
              mole_q  <= 8'h00;
              state_q <= S_END_OFF;
              fever_q <= 1'b0;
            end else begin
              timer_q <= timer_q - 8'd1;
              if (state_q == S_RUN) begin
                if (fever_go) begin
                  state_q     <= S_FEVER;
                  fever_cnt_q <= 4'd0;
                  mole_q      <= 8'hF0;
                  fever_q     <= 1'b1;
                end else begin
                  mole_q <= lfsr_q;
                  lfsr_q <= lfsr_d;
                end
              end else if (fever_cnt_d == FEVER_TICKS_L) begin
                state_q <= S_RUN;
                combo_q <= 4'd0;
                mole_q  <= lfsr_q;
                lfsr_q  <= lfsr_d;
                fever_q <= 1'b0;
              end else begin
                fever_cnt_q <= fever_cnt_d;
                mole_q      <= fever_cnt_d[0] ? 8'h0F : 8'hF0;
              end
            end
          end
        end
        S_END_OFF: begin
          if (tick_i) begin
            mole_q   <= 8'hFF;
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mole_o   = mole_q;
  assign score_o  = score_q;
  assign combo_o  = combo_q;
  assign timer_o  = timer_q;
  assign fever_o  = fever_q;
  assign finish_o = finish_q;

endmodule
